// File: rtl/id_ex_ctrl_stage.sv
// Decode plus ID/EX pipeline register. It feeds the EX-stage ALU its controls and immediate,
// resolves branches against EQ, and stalls the front end on a load-use hazard.
module id_ex_ctrl_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] incpc_in,
    input  logic            stall_in,
    input  logic            EQ,
    output logic [2:0]      ALUctrl,
    output logic            ALUsrc,
    output logic [XLEN-1:0] ImmOp,
    output logic            reg_jump,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] incPC,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            ex_valid,
    output logic            illegal,
    output logic            pc_src,
    output logic            stall_out
);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLT  = 3'b101,
        ALU_LINK = 3'b111
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    alu_op_e         d_alu;
    logic            d_legal, d_alusrc, d_reg_write, d_mem_write, d_mem_to_reg;
    logic            d_jump, d_branch, d_bne, d_reg_jump, d_uses_rs2;
    logic [XLEN-1:0] d_imm;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        d_legal      = 1'b0;
        d_alu        = ALU_ADD;
        d_alusrc     = 1'b0;
        d_imm        = '0;
        d_reg_write  = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_jump       = 1'b0;
        d_branch     = 1'b0;
        d_bne        = 1'b0;
        d_reg_jump   = 1'b0;
        d_uses_rs2   = 1'b0;
        unique case (opcode)
            OP_R: begin
                d_reg_write = 1'b1;
                d_uses_rs2  = 1'b1;
                unique case (funct3)
                    3'b000: begin
                        d_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        d_alu   = funct7[5] ? ALU_SUB : ALU_ADD;
                    end
                    3'b111: begin d_legal = (funct7 == 7'b0); d_alu = ALU_AND; end
                    3'b110: begin d_legal = (funct7 == 7'b0); d_alu = ALU_OR;  end
                    3'b010: begin d_legal = (funct7 == 7'b0); d_alu = ALU_SLT; end
                    default: d_legal = 1'b0;
                endcase
            end
            OP_I: begin
                d_alusrc    = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = imm_i;
                d_legal     = 1'b1;
                unique case (funct3)
                    3'b000:  d_alu = ALU_ADD;
                    3'b111:  d_alu = ALU_AND;
                    3'b110:  d_alu = ALU_OR;
                    3'b010:  d_alu = ALU_SLT;
                    default: d_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                d_legal      = (funct3 == 3'b010);
                d_alusrc     = 1'b1;
                d_imm        = imm_i;
                d_reg_write  = 1'b1;
                d_mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                d_legal     = (funct3 == 3'b010);
                d_alusrc    = 1'b1;
                d_imm       = imm_s;
                d_mem_write = 1'b1;
                d_uses_rs2  = 1'b1;
            end
            OP_BRANCH: begin
                d_legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
                d_alu      = ALU_SUB;
                d_imm      = imm_b;
                d_branch   = 1'b1;
                d_bne      = funct3[0];
                d_uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                d_legal     = 1'b1;
                d_alu       = ALU_LINK;
                d_imm       = imm_j;
                d_reg_write = 1'b1;
                d_jump      = 1'b1;
            end
            OP_JALR: begin
                // The jump target is rs1 itself; the I-immediate is carried but never added.
                d_legal     = (funct3 == 3'b000);
                d_alu       = ALU_LINK;
                d_imm       = imm_i;
                d_reg_write = 1'b1;
                d_jump      = 1'b1;
                d_reg_jump  = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase
    end

    logic ex_jump, ex_branch, ex_bne;
    logic hazard, load_bubble, issue;

    assign pc_src = ex_valid & (ex_jump | (ex_branch & (EQ ^ ex_bne)));
    assign hazard = instr_valid & ex_valid & mem_to_reg & (rd != 5'd0) &
                    ((rd == instr[19:15]) | (d_uses_rs2 & (rd == instr[24:20])));
    assign stall_out = hazard & ~pc_src;

    // Flush and load-use both force a bubble; stall_in only holds when neither applies.
    assign load_bubble = pc_src | hazard;
    assign issue       = ~load_bubble & instr_valid & d_legal;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUctrl    <= 3'b000;
            ALUsrc     <= 1'b0;
            ImmOp      <= '0;
            reg_jump   <= 1'b0;
            PC         <= '0;
            incPC      <= '0;
            rs1        <= 5'd0;
            rs2        <= 5'd0;
            rd         <= 5'd0;
            reg_write  <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            ex_valid   <= 1'b0;
            illegal    <= 1'b0;
            ex_jump    <= 1'b0;
            ex_branch  <= 1'b0;
            ex_bne     <= 1'b0;
        end else if (stall_in && !load_bubble) begin
            illegal <= 1'b0;
        end else begin
            ALUctrl    <= issue ? d_alu : ALU_ADD;
            ALUsrc     <= d_alusrc;
            ImmOp      <= d_imm;
            PC         <= pc_in;
            incPC      <= incpc_in;
            rs1        <= instr[19:15];
            rs2        <= instr[24:20];
            rd         <= instr[11:7];
            reg_jump   <= issue & d_reg_jump;
            reg_write  <= issue & d_reg_write;
            mem_write  <= issue & d_mem_write;
            mem_to_reg <= issue & d_mem_to_reg;
            ex_valid   <= issue;
            ex_jump    <= issue & d_jump;
            ex_branch  <= issue & d_branch;
            ex_bne     <= issue & d_bne;
            illegal    <= ~load_bubble & instr_valid & ~d_legal;
        end
    end

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage: decode, branch/jump flush, load-use stall, illegal,
// stall_in hold and reset in the middle of a hazard.
module tb_id_ex_ctrl_stage;

    localparam int XLEN = 32;

    localparam logic [31:0] I_ADD_X3   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADDI_M1  = 32'hFFF00293; // addi x5,x0,-1
    localparam logic [31:0] I_SLTI_M1  = 32'hFFF02293; // slti x5,x0,-1
    localparam logic [31:0] I_BEQ_16   = 32'h00208863; // beq  x1,x2,+16
    localparam logic [31:0] I_BNE_16   = 32'h00209863; // bne  x1,x2,+16
    localparam logic [31:0] I_JALR     = 32'h000300E7; // jalr x1,0(x6)
    localparam logic [31:0] I_LW_X7    = 32'h0000A383; // lw   x7,0(x1)
    localparam logic [31:0] I_ADD_X7   = 32'h00238433; // add  x8,x7,x2
    localparam logic [31:0] I_LW_X0    = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] I_ADD_X0   = 32'h00200433; // add  x8,x0,x2
    localparam logic [31:0] I_BAD      = 32'h0000007F;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     instr;
    logic            instr_valid;
    logic [XLEN-1:0] pc_in, incpc_in;
    logic            stall_in, EQ;
    logic [2:0]      ALUctrl;
    logic            ALUsrc, reg_jump, reg_write, mem_write, mem_to_reg;
    logic            ex_valid, illegal, pc_src, stall_out;
    logic [XLEN-1:0] ImmOp, PC, incPC;
    logic [4:0]      rs1, rs2, rd;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_ctrl_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .pc_in(pc_in), .incpc_in(incpc_in), .stall_in(stall_in), .EQ(EQ),
        .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmOp(ImmOp), .reg_jump(reg_jump),
        .PC(PC), .incPC(incPC), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ex_valid(ex_valid), .illegal(illegal), .pc_src(pc_src), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic [31:0] pc);
        instr       = i;
        instr_valid = v;
        pc_in       = pc;
        incpc_in    = pc + 32'd4;
    endtask

    // Outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        stall_in = 1'b0;
        EQ       = 1'b0;
        drive(32'h0, 1'b0, 32'h0);
        #12;
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_aluctrl", {29'b0, ALUctrl}, 32'd0);
        check("rst_reg_write", {31'b0, reg_write}, 32'd0);
        check("rst_pc", PC, 32'd0);
        check("rst_pc_src", {31'b0, pc_src}, 32'd0);
        check("rst_stall_out", {31'b0, stall_out}, 32'd0);
        rst_n = 1'b1;

        drive(I_ADD_X3, 1'b1, 32'h40);
        tick();
        check("add_aluctrl", {29'b0, ALUctrl}, 32'd0);
        check("add_alusrc", {31'b0, ALUsrc}, 32'd0);
        check("add_rs1", {27'b0, rs1}, 32'd1);
        check("add_rs2", {27'b0, rs2}, 32'd2);
        check("add_rd", {27'b0, rd}, 32'd3);
        check("add_reg_write", {31'b0, reg_write}, 32'd1);
        check("add_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("add_pc", PC, 32'h40);
        check("add_incpc", incPC, 32'h44);

        drive(I_ADDI_M1, 1'b1, 32'h44);
        tick();
        check("addi_alusrc", {31'b0, ALUsrc}, 32'd1);
        check("addi_imm", ImmOp, 32'hFFFF_FFFF);
        check("addi_aluctrl", {29'b0, ALUctrl}, 32'd0);
        check("addi_rd", {27'b0, rd}, 32'd5);

        drive(I_SLTI_M1, 1'b1, 32'h48);
        tick();
        check("slti_aluctrl", {29'b0, ALUctrl}, 32'd5);

        // beq taken: the following wrong-path add must be discarded.
        drive(I_BEQ_16, 1'b1, 32'h100);
        tick();
        check("beq_aluctrl", {29'b0, ALUctrl}, 32'd1);
        check("beq_imm", ImmOp, 32'd16);
        check("beq_pc", PC, 32'h100);
        drive(I_ADD_X3, 1'b1, 32'h104);
        EQ = 1'b1;
        #1;
        check("beq_eq1_pc_src", {31'b0, pc_src}, 32'd1);
        check("beq_flush_no_stall", {31'b0, stall_out}, 32'd0);
        tick();
        check("beq_flush_bubble", {31'b0, ex_valid}, 32'd0);
        check("beq_flush_reg_write", {31'b0, reg_write}, 32'd0);

        // beq not taken: the next instruction issues normally.
        drive(I_BEQ_16, 1'b1, 32'h100);
        tick();
        EQ = 1'b0;
        #1;
        check("beq_eq0_pc_src", {31'b0, pc_src}, 32'd0);
        drive(I_ADD_X3, 1'b1, 32'h104);
        tick();
        check("beq_nt_next_valid", {31'b0, ex_valid}, 32'd1);

        drive(I_BNE_16, 1'b1, 32'h108);
        tick();
        EQ = 1'b0;
        #1;
        check("bne_eq0_pc_src", {31'b0, pc_src}, 32'd1);
        EQ = 1'b1;
        #1;
        check("bne_eq1_pc_src", {31'b0, pc_src}, 32'd0);

        drive(I_JALR, 1'b1, 32'h200);
        tick();
        check("jalr_aluctrl", {29'b0, ALUctrl}, 32'd7);
        check("jalr_reg_jump", {31'b0, reg_jump}, 32'd1);
        check("jalr_pc_src", {31'b0, pc_src}, 32'd1);
        check("jalr_incpc", incPC, 32'h204);
        check("jalr_rs1", {27'b0, rs1}, 32'd6);
        drive(I_ADD_X3, 1'b1, 32'h204);
        tick();
        check("jalr_flush_bubble", {31'b0, ex_valid}, 32'd0);
        EQ = 1'b0;

        // Load-use: exactly one bubble, then the dependent add issues.
        drive(I_LW_X7, 1'b1, 32'h300);
        tick();
        check("lw_mem_to_reg", {31'b0, mem_to_reg}, 32'd1);
        check("lw_rd", {27'b0, rd}, 32'd7);
        drive(I_ADD_X7, 1'b1, 32'h304);
        #1;
        check("lu_stall_out", {31'b0, stall_out}, 32'd1);
        tick();
        check("lu_bubble", {31'b0, ex_valid}, 32'd0);
        check("lu_stall_released", {31'b0, stall_out}, 32'd0);
        tick();
        check("lu_add_valid", {31'b0, ex_valid}, 32'd1);
        check("lu_add_rd", {27'b0, rd}, 32'd8);

        drive(I_LW_X0, 1'b1, 32'h308);
        tick();
        drive(I_ADD_X0, 1'b1, 32'h30C);
        #1;
        check("lw_x0_no_stall", {31'b0, stall_out}, 32'd0);
        tick();
        check("lw_x0_add_valid", {31'b0, ex_valid}, 32'd1);

        drive(I_BAD, 1'b1, 32'h310);
        tick();
        check("bad_illegal", {31'b0, illegal}, 32'd1);
        check("bad_ex_valid", {31'b0, ex_valid}, 32'd0);
        drive(I_ADD_X3, 1'b1, 32'h314);
        tick();
        check("bad_illegal_pulse", {31'b0, illegal}, 32'd0);
        check("after_bad_valid", {31'b0, ex_valid}, 32'd1);

        // stall_in freezes the add x3 in EX while an addi waits upstream.
        stall_in = 1'b1;
        drive(I_ADDI_M1, 1'b1, 32'h318);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_rd", {27'b0, rd}, 32'd3);
            check("hold_alusrc", {31'b0, ALUsrc}, 32'd0);
            check("hold_pc", PC, 32'h314);
        end
        stall_in = 1'b0;
        tick();
        check("release_rd", {27'b0, rd}, 32'd5);
        check("release_alusrc", {31'b0, ALUsrc}, 32'd1);

        // Reset asserted in the middle of a load-use stall.
        drive(I_LW_X7, 1'b1, 32'h400);
        tick();
        drive(I_ADD_X7, 1'b1, 32'h404);
        #1;
        check("pre_rst_stall", {31'b0, stall_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall_out", {31'b0, stall_out}, 32'd0);
        check("mid_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("mid_rst_mem_to_reg", {31'b0, mem_to_reg}, 32'd0);
        check("mid_rst_rd", {27'b0, rd}, 32'd0);
        check("mid_rst_imm", ImmOp, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_add_valid", {31'b0, ex_valid}, 32'd1);
        check("post_rst_rd", {27'b0, rd}, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
